ov5640_size_cfg: RTL and testbench
==================================

# ov5640_size_cfg

Sequencer that writes the OV5640 output-size and frame-timing registers (DVPHO/DVPVO/HTS/VTS) over the shared SCCB/I2C command interface. It sits between the resolution lookup (cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel) and the I2C driver. It issues eight single-byte register writes on request, and re-issues them automatically when the selected resolution changes and stays stable.

## Interface
- WAIT_CYC, 1000: idle clocks between the completion of one write and the issue of the next.
- STABLE_CYC, 16: consecutive clocks the live size inputs must differ from the last written values before an automatic reconfiguration starts.
- ACK_TIMEOUT, 100000: clocks to wait for i2c_done after i2c_exec before aborting.
- clk  in  1  system clock; the only clock.
- rst_n  in  1  reset, asynchronous, active-low.
- cfg_start  in  1  single-cycle request to run the full write sequence.
- cmos_h_pixel  in  13  output width (DVPHO).
- cmos_v_pixel  in  13  output height (DVPVO).
- total_h_pixel  in  13  total line length (HTS).
- total_v_pixel  in  13  total frame length (VTS).
- i2c_done  in  1  single-cycle completion pulse from the I2C driver.
- i2c_exec  out  1  single-cycle write request to the I2C driver.
- i2c_data  out  24  {register address[15:0], data[7:0]}; stable from i2c_exec until i2c_done.
- cfg_busy  out  1  high while a sequence is in progress.
- cfg_done  out  1  level signal; high when the last sequence completed without error.
- cfg_err  out  1  single-cycle pulse on an acknowledge timeout.

## Operation
- Shadow registers sh_h, sh_v, sh_th, sh_tv (13 bits each) hold the values of the current or last sequence. Reset value is 0.
- Write table, indexed by idx 0..7 (3 bits):
  - 0x3808 = {3'b0, sh_h[12:8]}, 0x3809 = sh_h[7:0]
  - 0x380A = {3'b0, sh_v[12:8]}, 0x380B = sh_v[7:0]
  - 0x380C = {3'b0, sh_th[12:8]}, 0x380D = sh_th[7:0]
  - 0x380E = {3'b0, sh_tv[12:8]}, 0x380F = sh_tv[7:0]
- Trigger condition: valid only in IDLE. Either cfg_start = 1, or auto_go.
  - auto_go is set when stab_cnt reaches STABLE_CYC−1 while any live input differs from its shadow.
  - stab_cnt increments while the live inputs differ from the shadows. It clears when they are equal or when the FSM is not in IDLE.
  - Auto-retrigger is also active before the first sequence, because the shadows reset to 0.
  - cfg_start and auto_go in the same cycle produce one sequence.
- State machine:
  - IDLE: on trigger, go to LOAD.
  - LOAD: copy the live inputs into the shadows, idx←0, cfg_done←0. Go to ISSUE.
  - ISSUE: i2c_exec = 1 for this cycle only, drive i2c_data for the current idx, clear the timeout counter. Go to WAIT_ACK.
  - WAIT_ACK: on i2c_done, go to FINISH if idx = 7; otherwise idx←idx+1 and go to GAP. If the timeout counter reaches ACK_TIMEOUT−1 without i2c_done, pulse cfg_err, keep cfg_done = 0, and go to IDLE.
  - GAP: count WAIT_CYC cycles, then go to ISSUE.
  - FINISH: cfg_done←1, go to IDLE.
- cfg_busy = 1 in LOAD, ISSUE, WAIT_ACK, GAP and FINISH.
- cfg_start while busy is ignored; it is not queued.
- Input changes during a sequence do not affect it, because writes use the shadows. After the sequence returns to IDLE, the stability detector re-evaluates the inputs.
- An i2c_done outside WAIT_ACK is ignored.

## Timing
- Reset values: i2c_exec = 0, i2c_data = 0, cfg_busy = 0, cfg_done = 0, cfg_err = 0. FSM in IDLE, all counters 0.
- cfg_start sampled high at cycle t → LOAD at t+1 (cfg_busy high) → i2c_exec high at t+2.
- i2c_done sampled at cycle u (idx < 7) → GAP occupies u+1..u+WAIT_CYC → next i2c_exec at u+WAIT_CYC+1.
- Last i2c_done at u → FINISH at u+1 → cfg_done = 1 and cfg_busy = 0 from u+2.
- Auto trigger: inputs change at cycle c and then hold → LOAD at c+STABLE_CYC.
- Timeout: cfg_err pulses ACK_TIMEOUT cycles after the i2c_exec cycle. cfg_busy falls the following cycle.
- rst_n asserted mid-sequence: all outputs return to their reset values immediately. No partial state is retained.

## Test plan
- Inputs 480/272/1800/1000, cfg_start pulse, driver acknowledges each write after 5 cycles → i2c_data sequence 0x380801, 0x3809E0, 0x380A01, 0x380B10, 0x380C07, 0x380D08, 0x380E03, 0x380FE8; exactly 8 i2c_exec pulses; cfg_done high 2 cycles after the last i2c_done.
- With WAIT_CYC = 4, measure the gap from i2c_done to the next i2c_exec → exactly 5 clocks.
- After a completed configuration, switch the inputs to 1280/800/2570/980 and hold → new sequence starts STABLE_CYC cycles later; writes 0x380805, 0x380900, 0x380A03, 0x380B20, 0x380C0A, 0x380D0A, 0x380E03, 0x380FD4.
- Change the inputs at write index 3 and pulse cfg_start repeatedly while busy → remaining writes use the old values; no extra sequence starts until FINISH; one auto sequence with the new values follows.
- Never assert i2c_done, with ACK_TIMEOUT = 50 → cfg_err pulses once 50 cycles after i2c_exec; cfg_busy = 0 and cfg_done = 0 afterwards.
- Assert rst_n low during GAP → all outputs 0 asynchronously; after release with inputs ≠ 0 → auto sequence restarts from 0x3808.

Source files
------------

// File: rtl/ov5640_size_cfg.sv
// OV5640 output-size / frame-timing register sequencer.
// Issues eight single-byte SCCB writes (0x3808..0x380F) on request or after a stable resolution change.
module ov5640_size_cfg #(
  parameter int unsigned WAIT_CYC    = 1000,
  parameter int unsigned STABLE_CYC  = 16,
  parameter int unsigned ACK_TIMEOUT = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cfg_start,
  input  logic [12:0] cmos_h_pixel,
  input  logic [12:0] cmos_v_pixel,
  input  logic [12:0] total_h_pixel,
  input  logic [12:0] total_v_pixel,
  input  logic        i2c_done,
  output logic        i2c_exec,
  output logic [23:0] i2c_data,
  output logic        cfg_busy,
  output logic        cfg_done,
  output logic        cfg_err
);

  localparam int unsigned CNT_MAX = (ACK_TIMEOUT > WAIT_CYC) ? ACK_TIMEOUT : WAIT_CYC;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam int unsigned STB_W   = $clog2(STABLE_CYC + 1);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT_ACK,
    GAP,
    FINISH
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [STB_W-1:0]  stab_cnt;
  logic [2:0]        idx;
  logic [12:0]       sh_h, sh_v, sh_th, sh_tv;
  logic              differ;
  logic              auto_go;
  logic              trigger;
  logic              ack_to;
  logic              gap_end;
  logic [12:0]       sel_val;
  logic [7:0]        sel_byte;

  assign differ  = (cmos_h_pixel  != sh_h)  || (cmos_v_pixel  != sh_v) ||
                   (total_h_pixel != sh_th) || (total_v_pixel != sh_tv);
  assign auto_go = (state == IDLE) && differ && (stab_cnt == STB_W'(STABLE_CYC - 1));
  assign trigger = cfg_start || auto_go;
  assign ack_to  = (cnt == CNT_W'(ACK_TIMEOUT - 1));
  assign gap_end = (cnt == CNT_W'(WAIT_CYC - 1));

  // Register pairs: even idx carries bits [12:8], odd idx bits [7:0].
  always_comb begin
    sel_val = '0;
    unique case (idx[2:1])
      2'd0: sel_val = sh_h;
      2'd1: sel_val = sh_v;
      2'd2: sel_val = sh_th;
      2'd3: sel_val = sh_tv;
      default: sel_val = '0;
    endcase
    sel_byte = idx[0] ? sel_val[7:0] : {3'b000, sel_val[12:8]};
  end

  always_comb begin
    state_nx = state;
    i2c_exec = 1'b0;
    cfg_busy = 1'b1;
    cfg_err  = 1'b0;
    i2c_data = '0;
    unique case (state)
      IDLE: begin
        cfg_busy = 1'b0;
        if (trigger) state_nx = LOAD;
      end
      LOAD:  state_nx = ISSUE;
      ISSUE: begin
        i2c_exec = 1'b1;
        i2c_data = {13'h0701, idx, sel_byte};
        state_nx = WAIT_ACK;
      end
      WAIT_ACK: begin
        i2c_data = {13'h0701, idx, sel_byte};
        if (i2c_done) begin
          state_nx = (idx == 3'd7) ? FINISH : GAP;
        end else if (ack_to) begin
          cfg_err  = 1'b1;
          state_nx = IDLE;
        end
      end
      GAP: begin
        if (gap_end) state_nx = ISSUE;
      end
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      stab_cnt <= '0;
      idx      <= '0;
      sh_h     <= '0;
      sh_v     <= '0;
      sh_th    <= '0;
      sh_tv    <= '0;
      cfg_done <= 1'b0;
    end else begin
      state <= state_nx;

      if (state != IDLE || !differ) stab_cnt <= '0;
      else                          stab_cnt <= stab_cnt + 1'b1;

      unique case (state)
        LOAD: begin
          sh_h     <= cmos_h_pixel;
          sh_v     <= cmos_v_pixel;
          sh_th    <= total_h_pixel;
          sh_tv    <= total_v_pixel;
          idx      <= '0;
          cfg_done <= 1'b0;
        end
        ISSUE: cnt <= '0;
        WAIT_ACK: begin
          // The same counter times the ack wait and then the inter-write gap.
          if (i2c_done) begin
            cnt <= '0;
            if (idx != 3'd7) idx <= idx + 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP:     cnt <= cnt + 1'b1;
        FINISH:  cfg_done <= 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ov5640_size_cfg.sv
// Bench for ov5640_size_cfg: table of resolutions with expected write words,
// scoreboard queue checked on every i2c_exec, plus hand-written corner sequences.
module tb_ov5640_size_cfg;

  localparam int unsigned WAIT_CYC    = 4;
  localparam int unsigned STABLE_CYC  = 16;
  localparam int unsigned ACK_TIMEOUT = 50;
  localparam int          ACK_DLY     = 5;
  localparam int          BUDGET      = 600;

  logic        clk;
  logic        rst_n;
  logic        cfg_start;
  logic [12:0] cmos_h_pixel, cmos_v_pixel, total_h_pixel, total_v_pixel;
  logic        i2c_done;
  logic        i2c_exec;
  logic [23:0] i2c_data;
  logic        cfg_busy, cfg_done, cfg_err;

  ov5640_size_cfg #(
    .WAIT_CYC   (WAIT_CYC),
    .STABLE_CYC (STABLE_CYC),
    .ACK_TIMEOUT(ACK_TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_start    (cfg_start),
    .cmos_h_pixel (cmos_h_pixel),
    .cmos_v_pixel (cmos_v_pixel),
    .total_h_pixel(total_h_pixel),
    .total_v_pixel(total_v_pixel),
    .i2c_done     (i2c_done),
    .i2c_exec     (i2c_exec),
    .i2c_data     (i2c_data),
    .cfg_busy     (cfg_busy),
    .cfg_done     (cfg_done),
    .cfg_err      (cfg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [12:0]        h, v, th, tv;
    bit                 use_start;
    logic [0:7][23:0]   exp;
  } vec_t;

  vec_t        vecs[6];
  logic [23:0] exp_q[$];

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  int total_execs = 0, total_acks = 0;
  int last_exec_cyc = -1, last_done_cyc = -1, start_cyc = -1;
  int acks_in_seq = 0, ack_cnt = 0;
  int err_cnt = 0, err_cyc = -1;
  bit ack_en = 1'b1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // One clock: I2C driver model (ack after ACK_DLY) and scoreboard pop on i2c_exec.
  task automatic step();
    logic [23:0] w;
    @(negedge clk);
    cyc++;
    i2c_done = 1'b0;
    if (ack_cnt > 0) begin
      ack_cnt--;
      if (ack_cnt == 0) begin
        i2c_done = 1'b1;
        total_acks++;
        acks_in_seq++;
        last_done_cyc = (acks_in_seq < 8) ? cyc : -1;
      end
    end
    if (i2c_exec) begin
      total_execs++;
      if (last_done_cyc >= 0) check("gap_done_to_exec", cyc - last_done_cyc, WAIT_CYC + 1);
      last_done_cyc = -1;
      last_exec_cyc = cyc;
      check("sb_nonempty_at_exec", exp_q.size() > 0, 1);
      if (exp_q.size() > 0) begin
        w = exp_q.pop_front();
        check("i2c_data", i2c_data, w);
      end
      if (ack_en) ack_cnt = ACK_DLY;
    end
    if (cfg_err) begin
      err_cnt++;
      err_cyc = cyc;
    end
  endtask

  task automatic pulse_start();
    cfg_start = 1'b1;
    start_cyc = cyc;
    step();
    cfg_start = 1'b0;
  endtask

  task automatic set_inputs(input vec_t v);
    cmos_h_pixel  = v.h;
    cmos_v_pixel  = v.v;
    total_h_pixel = v.th;
    total_v_pixel = v.tv;
  endtask

  task automatic push_seq(input vec_t v);
    for (int i = 0; i < 8; i++) exp_q.push_back(v.exp[i]);
  endtask

  task automatic wait_execs(input int target, input string name);
    int b = 0;
    while (total_execs < target && b < BUDGET) begin step(); b++; end
    check(name, total_execs, target);
  endtask

  task automatic wait_acks(input int target, input string name);
    int b = 0;
    while (total_acks < target && b < BUDGET) begin step(); b++; end
    check(name, total_acks, target);
  endtask

  // Called at the cycle of the last i2c_done: FINISH next, then done/idle.
  task automatic check_finish();
    step();
    check("busy_in_finish", {cfg_busy, cfg_done}, 2'b10);
    step();
    check("done_after_seq", {cfg_busy, cfg_done}, 2'b01);
  endtask

  initial begin
    int base_e, base_a, chg_cyc, u, e, b;

    rst_n = 1'b0; cfg_start = 1'b0; i2c_done = 1'b0;
    cmos_h_pixel = '0; cmos_v_pixel = '0; total_h_pixel = '0; total_v_pixel = '0;

    vecs[0] = '{13'd480,  13'd272,  13'd1800, 13'd1000, 1'b1,
                {24'h380801, 24'h3809E0, 24'h380A01, 24'h380B10,
                 24'h380C07, 24'h380D08, 24'h380E03, 24'h380FE8}};
    vecs[1] = '{13'd1280, 13'd800,  13'd2570, 13'd980,  1'b0,
                {24'h380805, 24'h380900, 24'h380A03, 24'h380B20,
                 24'h380C0A, 24'h380D0A, 24'h380E03, 24'h380FD4}};
    vecs[2] = '{13'd640,  13'd480,  13'd1896, 13'd984,  1'b0,
                {24'h380802, 24'h380980, 24'h380A01, 24'h380BE0,
                 24'h380C07, 24'h380D68, 24'h380E03, 24'h380FD8}};
    vecs[3] = '{13'd800,  13'd600,  13'd1000, 13'd700,  1'b0,
                {24'h380803, 24'h380920, 24'h380A02, 24'h380B58,
                 24'h380C03, 24'h380DE8, 24'h380E02, 24'h380FBC}};
    vecs[4] = '{13'd1920, 13'd1080, 13'd2500, 13'd1120, 1'b1,
                {24'h380807, 24'h380980, 24'h380A04, 24'h380B38,
                 24'h380C09, 24'h380DC4, 24'h380E04, 24'h380F60}};
    vecs[5] = '{13'd1024, 13'd768,  13'd1500, 13'd800,  1'b1,
                {24'h380804, 24'h380900, 24'h380A03, 24'h380B00,
                 24'h380C05, 24'h380DDC, 24'h380E03, 24'h380F20}};

    repeat (3) step();
    check("reset_outputs", {i2c_exec, i2c_data, cfg_busy, cfg_done, cfg_err}, '0);
    rst_n = 1'b1;
    repeat (2) step();

    // Table: explicit start or automatic retrigger, full 8-write sequence each.
    for (int i = 0; i < 3; i++) begin
      base_e = total_execs; base_a = total_acks;
      acks_in_seq = 0; last_done_cyc = -1;
      push_seq(vecs[i]);
      set_inputs(vecs[i]);
      chg_cyc = cyc;
      if (vecs[i].use_start) pulse_start();
      wait_execs(base_e + 1, "first_exec");
      if (vecs[i].use_start) check("start_to_exec", last_exec_cyc - start_cyc, 2);
      else                   check("auto_to_exec", last_exec_cyc - chg_cyc, STABLE_CYC + 1);
      wait_acks(base_a + 8, "seq_acks");
      check_finish();
      repeat (20) step();
      check("execs_per_seq", total_execs - base_e, 8);
    end

    // Inputs change mid-sequence and starts while busy are dropped.
    base_e = total_execs; base_a = total_acks;
    acks_in_seq = 0; last_done_cyc = -1;
    push_seq(vecs[0]);
    set_inputs(vecs[0]);
    pulse_start();
    wait_execs(base_e + 4, "busy_idx3");
    set_inputs(vecs[3]);
    push_seq(vecs[3]);
    for (int k = 0; k < 6; k++) begin
      pulse_start();
      step();
    end
    wait_acks(base_a + 8, "old_seq_acks");
    u = cyc;
    acks_in_seq = 0;
    check_finish();
    wait_execs(base_e + 9, "auto_after_busy");
    check("auto_after_finish", last_exec_cyc - u, STABLE_CYC + 3);
    wait_acks(base_a + 16, "new_seq_acks");
    check_finish();
    // A stray i2c_done in IDLE must not start anything.
    i2c_done = 1'b1;
    repeat (10) step();
    check("idle_after_busy_test", {cfg_busy, 32'(total_execs - base_e)}, {1'b0, 32'd16});

    // Acknowledge timeout.
    ack_en = 1'b0;
    base_e = total_execs;
    acks_in_seq = 0; last_done_cyc = -1;
    exp_q.push_back(vecs[4].exp[0]);
    set_inputs(vecs[4]);
    pulse_start();
    wait_execs(base_e + 1, "timeout_exec");
    e = last_exec_cyc;
    err_cnt = 0; err_cyc = -1; b = 0;
    while (err_cnt == 0 && b < 200) begin step(); b++; end
    check("err_latency", err_cyc - e, ACK_TIMEOUT);
    step();
    check("idle_after_err", {cfg_busy, cfg_done}, 2'b00);
    repeat (5) step();
    check("err_pulses", err_cnt, 1);
    check("no_exec_after_err", total_execs - base_e, 1);
    ack_en = 1'b1;

    // Reset during GAP, then auto restart from shadow 0.
    base_a = total_acks;
    acks_in_seq = 0; last_done_cyc = -1;
    push_seq(vecs[5]);
    set_inputs(vecs[5]);
    pulse_start();
    wait_acks(base_a + 1, "pre_reset_ack");
    repeat (2) step();
    check("busy_before_rst", cfg_busy, 1'b1);
    rst_n = 1'b0;
    #1;
    check("async_reset_outputs", {i2c_exec, i2c_data, cfg_busy, cfg_done, cfg_err}, '0);
    ack_cnt = 0;
    exp_q.delete();
    repeat (2) step();
    push_seq(vecs[5]);
    acks_in_seq = 0; last_done_cyc = -1;
    base_e = total_execs; base_a = total_acks;
    rst_n = 1'b1;
    chg_cyc = cyc;
    wait_execs(base_e + 1, "post_reset_exec");
    check("post_reset_auto_lat", last_exec_cyc - chg_cyc, STABLE_CYC + 1);
    wait_acks(base_a + 8, "post_reset_acks");
    check_finish();

    check("sb_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
